// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
//   Tracks the running signed minimum and maximum of each frame of 8-bit
//   samples. Two eight_bit_comp instances compare each incoming sample against
//   the held max and the held min. When a frame closes, the block registers the
//   min and max values, the index where each first occurred, and the frame
//   length. It presents these on a valid/ready output handshake.
//
//   Ports
//     clk          in   rising-edge clock
//     reset        in   synchronous active-high reset
//     in_valid     in   in_data carries a sample
//     in_ready     out  a sample can be accepted this cycle
//     in_data      in   signed 8-bit sample
//     flush        in   close the current frame early (ACCUM only)
//     out_valid    out  frame result available
//     out_ready    in   downstream takes the result
//     out_min      out  signed frame minimum
//     out_max      out  signed frame maximum
//     out_min_idx  out  0-based index of the first occurrence of the minimum
//     out_max_idx  out  0-based index of the first occurrence of the maximum
//     out_len      out  number of samples in the frame
//
//   eight_bit_comp
//     Signed 8-bit magnitude comparator.
//     Inputs:  a_i, b_i.
//     Outputs: gt_o (a>b), eq_o (a==b), lt_o (a<b).
// -----------------------------------------------------------------------------

module eight_bit_comp (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic       gt_o,
   output logic       eq_o,
   output logic       lt_o
);
   assign gt_o = $signed(a_i) >  $signed(b_i);
   assign eq_o = a_i == b_i;
   assign lt_o = $signed(a_i) <  $signed(b_i);
endmodule

module minmax_tracker #(
   parameter int unsigned FRAME_LEN = 16,
   parameter int unsigned IDX_W     = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_min,
   output logic [7:0]       out_max,
   output logic [IDX_W-1:0] out_min_idx,
   output logic [IDX_W-1:0] out_max_idx,
   output logic [IDX_W-1:0] out_len
);

   typedef enum logic [1:0] {
      ST_FIRST,
      ST_ACCUM,
      ST_HOLD
   } state_t;

   localparam logic [IDX_W-1:0] LEN_FULL = IDX_W'(FRAME_LEN);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [7:0]       min_q, min_d, max_q, max_d;
   logic [IDX_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
   logic [7:0]       omin_q, omin_d, omax_q, omax_d;
   logic [IDX_W-1:0] omin_idx_q, omin_idx_d, omax_idx_q, omax_idx_d;
   logic [IDX_W-1:0] olen_q, olen_d;

   logic accept;
   logic gt_max, eq_max, lt_max;
   logic gt_min, eq_min, lt_min;
   logic unused_cmp;

   eight_bit_comp u_cmp_max (
      .a_i  (in_data),
      .b_i  (max_q),
      .gt_o (gt_max),
      .eq_o (eq_max),
      .lt_o (lt_max)
   );

   eight_bit_comp u_cmp_min (
      .a_i  (in_data),
      .b_i  (min_q),
      .gt_o (gt_min),
      .eq_o (eq_min),
      .lt_o (lt_min)
   );

   // Ties leave the held value alone, so only strict G/L drive updates.
   assign unused_cmp = ^{eq_max, lt_max, eq_min, gt_min};

   assign in_ready  = ~reset & (state_q != ST_HOLD);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == ST_HOLD);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      min_d      = min_q;
      max_d      = max_q;
      min_idx_d  = min_idx_q;
      max_idx_d  = max_idx_q;
      omin_d     = omin_q;
      omax_d     = omax_q;
      omin_idx_d = omin_idx_q;
      omax_idx_d = omax_idx_q;
      olen_d     = olen_q;

      unique case (state_q)
         ST_FIRST: begin
            if (accept) begin
               min_d     = in_data;
               max_d     = in_data;
               min_idx_d = '0;
               max_idx_d = '0;
               cnt_d     = IDX_W'(1);
               state_d   = ST_ACCUM;
               if (FRAME_LEN == 1) begin
                  state_d    = ST_HOLD;
                  omin_d     = in_data;
                  omax_d     = in_data;
                  omin_idx_d = '0;
                  omax_idx_d = '0;
                  olen_d     = IDX_W'(1);
               end
            end
         end

         ST_ACCUM: begin
            if (accept) begin
               if (gt_max) begin
                  max_d     = in_data;
                  max_idx_d = cnt_q;
               end
               if (lt_min) begin
                  min_d     = in_data;
                  min_idx_d = cnt_q;
               end
               cnt_d = cnt_q + IDX_W'(1);
            end
            // The result registers load from the next-state values, so a sample
            // accepted on the closing edge is part of the reported frame.
            if ((accept && cnt_d == LEN_FULL) || flush) begin
               state_d    = ST_HOLD;
               omin_d     = min_d;
               omax_d     = max_d;
               omin_idx_d = min_idx_d;
               omax_idx_d = max_idx_d;
               olen_d     = cnt_d;
            end
         end

         ST_HOLD: begin
            if (out_ready) begin
               state_d   = ST_FIRST;
               cnt_d     = '0;
               min_d     = '0;
               max_d     = '0;
               min_idx_d = '0;
               max_idx_d = '0;
            end
         end

         default: state_d = ST_FIRST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_FIRST;
         cnt_q      <= '0;
         min_q      <= '0;
         max_q      <= '0;
         min_idx_q  <= '0;
         max_idx_q  <= '0;
         omin_q     <= '0;
         omax_q     <= '0;
         omin_idx_q <= '0;
         omax_idx_q <= '0;
         olen_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         min_q      <= min_d;
         max_q      <= max_d;
         min_idx_q  <= min_idx_d;
         max_idx_q  <= max_idx_d;
         omin_q     <= omin_d;
         omax_q     <= omax_d;
         omin_idx_q <= omin_idx_d;
         omax_idx_q <= omax_idx_d;
         olen_q     <= olen_d;
      end
   end

   assign out_min     = omin_q;
   assign out_max     = omax_q;
   assign out_min_idx = omin_idx_q;
   assign out_max_idx = omax_idx_q;
   assign out_len     = olen_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmax_tracker
//   Directed bench for minmax_tracker.
//   It runs one instance with FRAME_LEN=4 (u4) and one with FRAME_LEN=16 (u16).
//   The two instances share clk, reset, in_data, flush and out_ready.
//   Each instance has its own in_valid.
// -----------------------------------------------------------------------------

module tb_minmax_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       flush;
   logic       out_ready;

   logic       in_valid4, in_ready4, out_valid4;
   logic [7:0] out_min4, out_max4;
   logic [2:0] out_min_idx4, out_max_idx4, out_len4;

   logic       in_valid16, in_ready16, out_valid16;
   logic [7:0] out_min16, out_max16;
   logic [4:0] out_min_idx16, out_max_idx16, out_len16;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   minmax_tracker #(.FRAME_LEN(4), .IDX_W(3)) u4 (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid4),
      .in_ready    (in_ready4),
      .in_data     (in_data),
      .flush       (flush),
      .out_valid   (out_valid4),
      .out_ready   (out_ready),
      .out_min     (out_min4),
      .out_max     (out_max4),
      .out_min_idx (out_min_idx4),
      .out_max_idx (out_max_idx4),
      .out_len     (out_len4)
   );

   minmax_tracker #(.FRAME_LEN(16), .IDX_W(5)) u16 (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid16),
      .in_ready    (in_ready16),
      .in_data     (in_data),
      .flush       (flush),
      .out_valid   (out_valid16),
      .out_ready   (out_ready),
      .out_min     (out_min16),
      .out_max     (out_max16),
      .out_min_idx (out_min_idx16),
      .out_max_idx (out_max_idx16),
      .out_len     (out_len16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are observed 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send4(input logic [7:0] d);
      in_data   = d;
      in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
   endtask

   task automatic send16(input logic [7:0] d, input logic fl);
      in_data    = d;
      in_valid16 = 1'b1;
      flush      = fl;
      step();
      in_valid16 = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic check4(input string tag, input logic [7:0] mn, input logic [2:0] mni,
                         input logic [7:0] mx, input logic [2:0] mxi, input logic [2:0] len);
      check({tag, ".valid"},   out_valid4,   1);
      check({tag, ".min"},     out_min4,     mn);
      check({tag, ".min_idx"}, out_min_idx4, mni);
      check({tag, ".max"},     out_max4,     mx);
      check({tag, ".max_idx"}, out_max_idx4, mxi);
      check({tag, ".len"},     out_len4,     len);
   endtask

   task automatic check16(input string tag, input logic [7:0] mn, input logic [4:0] mni,
                          input logic [7:0] mx, input logic [4:0] mxi, input logic [4:0] len);
      check({tag, ".valid"},   out_valid16,   1);
      check({tag, ".min"},     out_min16,     mn);
      check({tag, ".min_idx"}, out_min_idx16, mni);
      check({tag, ".max"},     out_max16,     mx);
      check({tag, ".max_idx"}, out_max_idx16, mxi);
      check({tag, ".len"},     out_len16,     len);
   endtask

   initial begin
      reset      = 1'b1;
      in_data    = 8'h00;
      flush      = 1'b0;
      out_ready  = 1'b0;
      in_valid4  = 1'b0;
      in_valid16 = 1'b0;
      step();
      check("rst.in_ready_during", in_ready4, 0);
      step();
      reset = 1'b0;
      #1;
      check("rst.out_valid4",  out_valid4,  0);
      check("rst.out_valid16", out_valid16, 0);
      check("rst.in_ready4",   in_ready4,   1);
      check("rst.out_min4",    out_min4,    0);
      check("rst.out_len16",   out_len16,   0);

      // 1: extremes back-to-back
      send4(8'd5);
      send4(8'hFD);
      send4(8'd127);
      check("t1.not_yet", out_valid4, 0);
      send4(8'h80);
      check4("t1", 8'h80, 3'd3, 8'h7F, 3'd2, 3'd4);
      handshake();
      check("t1.released", out_valid4, 0);

      // 2: ties keep the earliest index
      send4(8'd7);
      send4(8'd7);
      send4(8'd2);
      send4(8'd2);
      check4("t2", 8'd2, 3'd2, 8'd7, 3'd0, 3'd4);
      handshake();

      // 3: flush with the closing accept, then flush alone in FIRST
      send16(8'd10, 1'b0);
      send16(8'd20, 1'b0);
      send16(8'hFF, 1'b1);
      check16("t3", 8'hFF, 5'd2, 8'd20, 5'd1, 5'd3);
      handshake();
      flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3.flush_first_no_valid", out_valid16, 0);
      end
      flush = 1'b0;

      // flush without an accept closes the frame at the current count
      send16(8'd3, 1'b0);
      send16(8'hF9, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check16("t3b", 8'hF9, 5'd1, 8'd3, 5'd0, 5'd2);
      handshake();

      // 4: backpressure in HOLD
      send4(8'd1);
      send4(8'd2);
      send4(8'd3);
      send4(8'd4);
      in_valid4 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'(8'd90 + i);
         step();
         check("t4.in_ready_hold", in_ready4, 0);
      end
      check4("t4.held", 8'd1, 3'd0, 8'd4, 3'd3, 3'd4);
      in_data   = 8'hFB;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t4.valid_drop", out_valid4, 0);
      check("t4.in_ready_back", in_ready4, 1);
      step();
      in_valid4 = 1'b0;
      send4(8'd3);
      send4(8'd3);
      send4(8'd0);
      check4("t4.next", 8'hFB, 3'd0, 8'd3, 3'd1, 3'd4);
      handshake();

      // 5: reset mid-frame discards it
      send4(8'd10);
      send4(8'd20);
      reset = 1'b1;
      #1;
      check("t5.in_ready_in_reset", in_ready4, 0);
      step();
      reset = 1'b0;
      #1;
      check("t5.valid",   out_valid4,   0);
      check("t5.min",     out_min4,     0);
      check("t5.max",     out_max4,     0);
      check("t5.min_idx", out_min_idx4, 0);
      check("t5.len",     out_len4,     0);
      send4(8'd1);
      send4(8'd2);
      send4(8'd3);
      check("t5.no_early_valid", out_valid4, 0);
      send4(8'd4);
      check4("t5.fresh", 8'd1, 3'd0, 8'd4, 3'd3, 3'd4);
      handshake();

      // 6: constant -128 with random gaps; in_data wanders while idle
      for (int i = 0; i < 16; i++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            in_data = 8'($urandom);
            step();
         end
         send16(8'h80, 1'b0);
         if (i < 15) check("t6.open", out_valid16, 0);
      end
      check16("t6", 8'h80, 5'd0, 8'h80, 5'd0, 5'd16);
      handshake();
      check("t6.released", out_valid16, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
